// File: rtl/shift_rot_pkg.sv
// ============================================================================
// Module   : shift_rot_pkg
// Brief    : Op codes, FSM state encoding and shift directions for shift_rot_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_rot_pkg;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_rot_sched_if.sv
// ============================================================================
// Module   : shift_rot_sched_if
// Brief    : Two request channels and one response channel of shift_rot_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_rot_sched_if #(
    parameter int W  = 16,
    parameter int AW = 4
);
    logic          req0_valid;
    logic          req0_ready;
    logic [W-1:0]  req0_x;
    logic [AW-1:0] req0_amt;
    logic [1:0]    req0_op;
    logic          req1_valid;
    logic          req1_ready;
    logic [W-1:0]  req1_x;
    logic [AW-1:0] req1_amt;
    logic [1:0]    req1_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_id;

    modport master (
        output req0_valid, req0_x, req0_amt, req0_op,
        output req1_valid, req1_x, req1_amt, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_x, req0_amt, req0_op,
        input  req1_valid, req1_x, req1_amt, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

`default_nettype wire

// File: rtl/shifter_16b_top.sv
// ============================================================================
// Module   : shifter_16b_top
// Brief    : Combinational 16-bit logical barrel shifter, dir 0 = left, 1 = right.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shifter_16b_top
    import shift_rot_pkg::*;
(
    output logic [15:0] out,
    input  logic [15:0] x,
    input  logic [3:0]  shift,
    input  logic        dir
);

    logic [15:0] w_stage [0:4];

    assign w_stage[0] = x;

    for (genvar i = 0; i < 4; i++) begin : g_stage
        localparam int c_DIST = 1 << i;
        assign w_stage[i+1] = !shift[i]           ? w_stage[i] :
                              (dir == DIR_RIGHT)  ? (w_stage[i] >> c_DIST) :
                                                    (w_stage[i] << c_DIST);
    end

    assign out = w_stage[4];

endmodule

`default_nettype wire

// File: rtl/shift_rot_sched.sv
// ============================================================================
// Module   : shift_rot_sched
// Brief    : Arbitrates two requesters onto one barrel shifter; rotates use two passes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_rot_sched
    import shift_rot_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_rot_sched_if.slave     bus,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_PASS1 = PASS1;
    localparam logic [1:0] c_PASS2 = PASS2;
    localparam logic [1:0] c_RESP  = RESP;

    logic [1:0]    r_state;
    logic [W-1:0]  r_x;
    logic [AW-1:0] r_amt;
    op_t           r_op;
    logic          r_id;
    logic          r_last_grant;
    logic [W-1:0]  r_acc;

    logic          w_idle;
    logic          w_gnt1;
    logic          w_accept;
    logic          w_rotate;
    logic [AW-1:0] w_sh_amt;
    logic          w_sh_dir;
    logic [W-1:0]  w_sh_out;

    assign w_idle   = (r_state == c_IDLE);
    // req1 wins when alone, or on a tie when req0 was granted last
    assign w_gnt1   = bus.req1_valid && (!bus.req0_valid || (r_last_grant == 1'b0));
    assign w_accept = w_idle && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = w_idle && bus.req0_valid && !w_gnt1;
    assign bus.req1_ready = w_idle && w_gnt1;

    assign w_rotate = (r_op == OP_ROL) || (r_op == OP_ROR);
    // Second pass shifts by (16 - amt) mod 16 in the opposite direction
    assign w_sh_amt = (r_state == c_PASS2) ? (-r_amt) : r_amt;
    assign w_sh_dir = (((r_op == OP_SHR) || (r_op == OP_ROR)) ? DIR_RIGHT : DIR_LEFT)
                      ^ (r_state == c_PASS2);

    shifter_16b_top u_shifter (
        .out   (w_sh_out),
        .x     (r_x),
        .shift (w_sh_amt),
        .dir   (w_sh_dir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_x          <= '0;
            r_amt        <= '0;
            r_op         <= OP_SHL;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_acc        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_x          <= w_gnt1 ? bus.req1_x : bus.req0_x;
                        r_amt        <= w_gnt1 ? bus.req1_amt : bus.req0_amt;
                        r_op         <= op_t'(w_gnt1 ? bus.req1_op : bus.req0_op);
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_state      <= c_PASS1;
                    end
                end
                c_PASS1: begin
                    r_acc   <= w_sh_out;
                    r_state <= (w_rotate && (r_amt != '0)) ? c_PASS2 : c_RESP;
                end
                c_PASS2: begin
                    r_acc   <= r_acc | w_sh_out;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (r_state == c_RESP);
    assign bus.rsp_data  = r_acc;
    assign bus.rsp_id    = r_id;
    assign busy          = !w_idle;

endmodule

`default_nettype wire
